reg_file_param: RTL and testbench

Parametrised multi-port register file for the single-cycle and pipelined datapaths. It generalises the fixed 16 x 16-bit, one-write/two-read file to configurable width and depth, and adds several features:
- a second write port with defined collision priority;
- optional write-to-read bypass;
- an optional hardwired-zero register;
- a per-register busy scoreboard so a pipelined control unit can detect operands still in flight.

It sits between the decode stage (read addresses, reservations) and the writeback stage (write ports).

---
 rtl/reg_file_param.sv | 117 +++++++++++
 tb/tb_reg_file_param.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Purpose: parametrised 2-write/2-read register file with optional bypass, zero register and busy scoreboard.
// Latency: writes and reservations land on the next rising edge; read and busy outputs are combinational.
// Backpressure: none; every write, reserve and flush request is accepted in the cycle it is presented.
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              nClear,
    input  logic [ADDR_W-1:0] Aaddr,
    input  logic [ADDR_W-1:0] Baddr,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic [ADDR_W-1:0] Caddr,
    input  logic [DATA_W-1:0] C,
    input  logic              load,
    input  logic [ADDR_W-1:0] Daddr,
    input  logic [DATA_W-1:0] D,
    input  logic              loadD,
    input  logic              reserve,
    input  logic [ADDR_W-1:0] Raddr,
    input  logic              flush,
    output logic              busyA,
    output logic              busyB
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic HAS_ZERO = (ZERO_REG != 0);
    localparam logic HAS_BYP  = (BYPASS != 0);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic we_c;
    logic we_d;
    logic rsv_vld;

    // Port D loses to port C on a shared address; address 0 is inert when hardwired to zero.
    always_comb begin
        we_c    = load && !(HAS_ZERO && (Caddr == ADDR_ZERO));
        we_d    = loadD && !(HAS_ZERO && (Daddr == ADDR_ZERO))
                  && !(load && (Caddr == Daddr));
        rsv_vld = reserve && !flush && !(HAS_ZERO && (Raddr == ADDR_ZERO));
    end

    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_c) begin
                regs[Caddr] <= C;
            end
            if (we_d) begin
                regs[Daddr] <= D;
            end
        end
    end

    // Flush beats everything; a reservation beats a completing write so the newest producer is tracked.
    always_ff @(posedge clk or negedge nClear) begin
        if (!nClear) begin
            busy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    busy[i] <= 1'b0;
                end else if (rsv_vld && (Raddr == ADDR_W'(i))) begin
                    busy[i] <= 1'b1;
                end else if ((we_c && (Caddr == ADDR_W'(i))) ||
                             (we_d && (Daddr == ADDR_W'(i)))) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    logic a_hit_c, a_hit_d, b_hit_c, b_hit_d;
    logic a_zero, b_zero;

    always_comb begin
        a_hit_c = HAS_BYP && we_c && (Caddr == Aaddr);
        a_hit_d = HAS_BYP && we_d && (Daddr == Aaddr);
        b_hit_c = HAS_BYP && we_c && (Caddr == Baddr);
        b_hit_d = HAS_BYP && we_d && (Daddr == Baddr);
        a_zero  = HAS_ZERO && (Aaddr == ADDR_ZERO);
        b_zero  = HAS_ZERO && (Baddr == ADDR_ZERO);
    end

    always_comb begin
        A = regs[Aaddr];
        if (a_zero) begin
            A = '0;
        end else if (a_hit_c) begin
            A = C;
        end else if (a_hit_d) begin
            A = D;
        end

        B = regs[Baddr];
        if (b_zero) begin
            B = '0;
        end else if (b_hit_c) begin
            B = C;
        end else if (b_hit_d) begin
            B = D;
        end

        busyA = busy[Aaddr] && !a_zero && !a_hit_c && !a_hit_d;
        busyB = busy[Baddr] && !b_zero && !b_hit_c && !b_hit_d;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: three instances (bypass, no bypass, zero register) share one stimulus stream.
module tb_reg_file_param;

    logic        clk;
    logic        nClear;
    logic [3:0]  Aaddr, Baddr, Caddr, Daddr, Raddr;
    logic [15:0] C, D;
    logic        load, loadD, reserve, flush;

    logic [15:0] a_byp, b_byp, a_nb, b_nb, a_z, b_z;
    logic        ba_byp, bb_byp, ba_nb, bb_nb, ba_z, bb_z;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(1)) dut (
        .clk(clk), .nClear(nClear), .Aaddr(Aaddr), .Baddr(Baddr), .A(a_byp), .B(b_byp),
        .Caddr(Caddr), .C(C), .load(load), .Daddr(Daddr), .D(D), .loadD(loadD),
        .reserve(reserve), .Raddr(Raddr), .flush(flush), .busyA(ba_byp), .busyB(bb_byp));

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_nb (
        .clk(clk), .nClear(nClear), .Aaddr(Aaddr), .Baddr(Baddr), .A(a_nb), .B(b_nb),
        .Caddr(Caddr), .C(C), .load(load), .Daddr(Daddr), .D(D), .loadD(loadD),
        .reserve(reserve), .Raddr(Raddr), .flush(flush), .busyA(ba_nb), .busyB(bb_nb));

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_z (
        .clk(clk), .nClear(nClear), .Aaddr(Aaddr), .Baddr(Baddr), .A(a_z), .B(b_z),
        .Caddr(Caddr), .C(C), .load(load), .Daddr(Daddr), .D(D), .loadD(loadD),
        .reserve(reserve), .Raddr(Raddr), .flush(flush), .busyA(ba_z), .busyB(bb_z));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load = 1'b0; loadD = 1'b0; reserve = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (a_byp !== 16'h0000) begin n_fail++; $display("FAIL reset_A: got %h want 0000", a_byp); end
        n_checks++; if (b_nb !== 16'h0000) begin n_fail++; $display("FAIL reset_B_nb: got %h want 0000", b_nb); end
        n_checks++; if (ba_byp !== 1'b0 || bb_byp !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b%b want 00", ba_byp, bb_byp); end
        // put non-zero data into 1 and 2, then reset mid-cycle
        load = 1'b1; Caddr = 4'd1; C = 16'h1111;
        loadD = 1'b1; Daddr = 4'd2; D = 16'h2222;
        reserve = 1'b1; Raddr = 4'd1;
        cycle();
        idle(); Aaddr = 4'd1; Baddr = 4'd2;
        #1;
        n_checks++; if (a_byp !== 16'h1111 || b_byp !== 16'h2222) begin n_fail++; $display("FAIL pre_reset_data: got %h %h want 1111 2222", a_byp, b_byp); end
        #1 nClear = 1'b0;
        #1;
        n_checks++; if (a_byp !== 16'h0000 || b_byp !== 16'h0000) begin n_fail++; $display("FAIL async_reset_data: got %h %h want 0000 0000", a_byp, b_byp); end
        n_checks++; if (ba_byp !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b want 0", ba_byp); end
        #3 nClear = 1'b1;
        cycle();
        load = 1'b1; Caddr = 4'd5; C = 16'h1234;
        cycle();
        idle(); Aaddr = 4'd5;
        #1;
        n_checks++; if (a_byp !== 16'h1234 || a_nb !== 16'h1234) begin n_fail++; $display("FAIL write_then_read: got %h %h want 1234", a_byp, a_nb); end
    endtask

    task automatic test_collision();
        load = 1'b1; Caddr = 4'd3; C = 16'hAAAA;
        loadD = 1'b1; Daddr = 4'd3; D = 16'h5555;
        Aaddr = 4'd3;
        #1;
        n_checks++; if (a_byp !== 16'hAAAA) begin n_fail++; $display("FAIL collision_bypass: got %h want AAAA", a_byp); end
        cycle();
        idle();
        #1;
        n_checks++; if (a_byp !== 16'hAAAA || a_nb !== 16'hAAAA) begin n_fail++; $display("FAIL collision_same_addr: got %h %h want AAAA", a_byp, a_nb); end
        load = 1'b1; Caddr = 4'd3; C = 16'hAAAA;
        loadD = 1'b1; Daddr = 4'd4; D = 16'h5555;
        cycle();
        idle(); Aaddr = 4'd3; Baddr = 4'd4;
        #1;
        n_checks++; if (a_byp !== 16'hAAAA || b_byp !== 16'h5555) begin n_fail++; $display("FAIL collision_diff_addr: got %h %h want AAAA 5555", a_byp, b_byp); end
    endtask

    task automatic test_bypass();
        load = 1'b1; Caddr = 4'd7; C = 16'hBEEF; Aaddr = 4'd7;
        loadD = 1'b1; Daddr = 4'd8; D = 16'h1111; Baddr = 4'd8;
        #1;
        n_checks++; if (a_byp !== 16'hBEEF) begin n_fail++; $display("FAIL bypass_C: got %h want BEEF", a_byp); end
        n_checks++; if (b_byp !== 16'h1111) begin n_fail++; $display("FAIL bypass_D: got %h want 1111", b_byp); end
        n_checks++; if (a_nb !== 16'h0000 || b_nb !== 16'h0000) begin n_fail++; $display("FAIL no_bypass_old: got %h %h want 0000 0000", a_nb, b_nb); end
        cycle();
        idle();
        #1;
        n_checks++; if (a_nb !== 16'hBEEF || b_nb !== 16'h1111) begin n_fail++; $display("FAIL no_bypass_after_edge: got %h %h want BEEF 1111", a_nb, b_nb); end
    endtask

    task automatic test_scoreboard();
        reserve = 1'b1; Raddr = 4'd9; Aaddr = 4'd9;
        #1;
        n_checks++; if (ba_byp !== 1'b0) begin n_fail++; $display("FAIL reserve_not_yet: got %b want 0", ba_byp); end
        cycle();
        idle();
        #1;
        n_checks++; if (ba_byp !== 1'b1 || ba_nb !== 1'b1) begin n_fail++; $display("FAIL reserve_busy: got %b %b want 1 1", ba_byp, ba_nb); end
        loadD = 1'b1; Daddr = 4'd9; D = 16'h0909;
        #1;
        n_checks++; if (ba_byp !== 1'b0) begin n_fail++; $display("FAIL busy_bypass_clear: got %b want 0", ba_byp); end
        n_checks++; if (ba_nb !== 1'b1) begin n_fail++; $display("FAIL busy_no_bypass_hold: got %b want 1", ba_nb); end
        cycle();
        idle();
        #1;
        n_checks++; if (ba_byp !== 1'b0 || ba_nb !== 1'b0) begin n_fail++; $display("FAIL busy_cleared: got %b %b want 0 0", ba_byp, ba_nb); end
        n_checks++; if (a_byp !== 16'h0909) begin n_fail++; $display("FAIL writeD_data: got %h want 0909", a_byp); end
        reserve = 1'b1; Raddr = 4'd9; load = 1'b1; Caddr = 4'd9; C = 16'h9999;
        cycle();
        idle();
        #1;
        n_checks++; if (ba_byp !== 1'b1 || ba_nb !== 1'b1) begin n_fail++; $display("FAIL reserve_wins_write: got %b %b want 1 1", ba_byp, ba_nb); end
    endtask

    task automatic test_flush();
        reserve = 1'b1;
        Raddr = 4'd2;  cycle();
        Raddr = 4'd6;  cycle();
        Raddr = 4'd10; cycle();
        idle(); Aaddr = 4'd2; Baddr = 4'd6;
        #1;
        n_checks++; if (ba_byp !== 1'b1 || bb_byp !== 1'b1) begin n_fail++; $display("FAIL reserved_before_flush: got %b %b want 1 1", ba_byp, bb_byp); end
        flush = 1'b1; reserve = 1'b1; Raddr = 4'd11;
        cycle();
        idle();
        #1;
        n_checks++; if (ba_byp !== 1'b0 || bb_byp !== 1'b0) begin n_fail++; $display("FAIL flush_2_6: got %b %b want 0 0", ba_byp, bb_byp); end
        Aaddr = 4'd10; Baddr = 4'd11;
        #1;
        n_checks++; if (ba_byp !== 1'b0 || bb_byp !== 1'b0) begin n_fail++; $display("FAIL flush_10_11: got %b %b want 0 0", ba_byp, bb_byp); end
        Aaddr = 4'd9; Baddr = 4'd3;
        #1;
        n_checks++; if (ba_byp !== 1'b0) begin n_fail++; $display("FAIL flush_9: got %b want 0", ba_byp); end
        n_checks++; if (a_byp !== 16'h9999 || b_byp !== 16'hAAAA) begin n_fail++; $display("FAIL flush_data_kept: got %h %h want 9999 AAAA", a_byp, b_byp); end
    endtask

    task automatic test_zero_reg();
        load = 1'b1; Caddr = 4'd0; C = 16'hFFFF;
        reserve = 1'b1; Raddr = 4'd0; Aaddr = 4'd0;
        #1;
        n_checks++; if (a_z !== 16'h0000 || ba_z !== 1'b0) begin n_fail++; $display("FAIL zero_bypass: got %h %b want 0000 0", a_z, ba_z); end
        n_checks++; if (a_byp !== 16'hFFFF) begin n_fail++; $display("FAIL r0_normal_bypass: got %h want FFFF", a_byp); end
        cycle();
        idle();
        #1;
        n_checks++; if (a_z !== 16'h0000 || ba_z !== 1'b0) begin n_fail++; $display("FAIL zero_after_edge: got %h %b want 0000 0", a_z, ba_z); end
        n_checks++; if (a_byp !== 16'hFFFF || ba_byp !== 1'b1) begin n_fail++; $display("FAIL r0_normal_after: got %h %b want FFFF 1", a_byp, ba_byp); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            load = 1'b1; Caddr = 4'(12 + i); C = 16'hC000 + 16'(i);
            loadD = 1'b1; Daddr = 4'(12 + i); D = 16'hD000;
            cycle();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            Aaddr = 4'(12 + i);
            #1;
            n_checks++; if (a_nb !== 16'hC000 + 16'(i)) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", i, a_nb, 16'hC000 + 16'(i)); end
        end
    endtask

    initial begin
        nClear = 1'b0;
        Aaddr = '0; Baddr = '0; Caddr = '0; Daddr = '0; Raddr = '0;
        C = '0; D = '0;
        idle();
        #12 nClear = 1'b1;
        #1;
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_zero_reg();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
